// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard control block: FSM state
// encoding and default widths used by hazard_ctrl_unit and its helpers.
package hazard_pkg;

  localparam int HZ_REG_ADDR_W_DEF   = 5;
  localparam int HZ_LU_STALL_CYC_DEF = 1;
  localparam int HZ_CNT_W_DEF        = 3;
  localparam int HZ_PERF_CNT_W       = 32;

  typedef enum logic [1:0] {
    HZ_IDLE     = 2'd0,
    HZ_LU_STALL = 2'd1,
    HZ_BR_PEND  = 2'd2
  } hz_state_e;

endpackage

// File: rtl/hazard_perf_cnt.sv
// Optional performance counters for hazard_ctrl_unit: load-use stall cycles,
// freeze cycles and branch flush events. All counters wrap modulo 2^32.
module hazard_perf_cnt
  import hazard_pkg::*;
(
  input  logic                     clk_i,
  input  logic                     rst_n,
  input  logic                     stall_i,
  input  logic                     freeze_i,
  input  logic                     flush_i,
  output logic [HZ_PERF_CNT_W-1:0] LU_stall_cnt_o,
  output logic [HZ_PERF_CNT_W-1:0] Freeze_cnt_o,
  output logic [HZ_PERF_CNT_W-1:0] Flush_cnt_o
);

  // Count qualifying cycles; natural overflow gives the modulo wrap.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      LU_stall_cnt_o <= '0;
      Freeze_cnt_o   <= '0;
      Flush_cnt_o    <= '0;
    end else begin
      if (stall_i)  LU_stall_cnt_o <= LU_stall_cnt_o + HZ_PERF_CNT_W'(1);
      if (freeze_i) Freeze_cnt_o   <= Freeze_cnt_o + HZ_PERF_CNT_W'(1);
      if (flush_i)  Flush_cnt_o    <= Flush_cnt_o + HZ_PERF_CNT_W'(1);
    end
  end

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Stall / flush / freeze controller for the 5-stage RV32IC pipeline.
// Detects load-use hazards (multi-cycle bubbles), freezes the whole pipe on
// I/D-cache miss and defers a branch redirect that arrives during a freeze so
// the flush is applied exactly once afterwards.
// Optional build macro: HAZARD_PERF_CNT_EN adds stall/freeze/flush counters.
module hazard_ctrl_unit
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W   = HZ_REG_ADDR_W_DEF,
  parameter int LU_STALL_CYC = HZ_LU_STALL_CYC_DEF,
  parameter int CNT_W        = HZ_CNT_W_DEF
) (
  input  logic                  clk_i,
  input  logic                  rst_n,
  input  logic                  IDEX_MemRead_i,
  input  logic [REG_ADDR_W-1:0] IDEX_RDaddr_i,
  input  logic [REG_ADDR_W-1:0] IFID_RS1addr_i,
  input  logic [REG_ADDR_W-1:0] IFID_RS2addr_i,
  input  logic                  IFID_RS1used_i,
  input  logic                  IFID_RS2used_i,
  input  logic                  BranchOrJump_i,
  input  logic                  ICache_stall_i,
  input  logic                  DCache_stall_i,
  output logic                  Stall_load_use_o,
  output logic                  Flush_IFID_o,
  output logic                  Flush_IDEX_o,
  output logic                  Freeze_o,
  output logic [1:0]            State_o
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [HZ_PERF_CNT_W-1:0] LU_stall_cnt_o,
  output logic [HZ_PERF_CNT_W-1:0] Freeze_cnt_o,
  output logic [HZ_PERF_CNT_W-1:0] Flush_cnt_o
`endif
);

  // With a single bubble the IDLE cycle itself is the whole stall.
  localparam bit MULTI_BUBBLE = (LU_STALL_CYC > 1);

  hz_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             br_pend_q, br_pend_d;

  logic lu_hit;
  logic freeze;
  logic stall_c;
  logic flush_ifid_c;
  logic flush_idex_c;

  // Load-use hazard: only source fields the ID instruction really reads count,
  // and x0 never carries a dependency.
  always_comb begin
    lu_hit = IDEX_MemRead_i && (IDEX_RDaddr_i != '0) &&
             ((IFID_RS1used_i && (IDEX_RDaddr_i == IFID_RS1addr_i)) ||
              (IFID_RS2used_i && (IDEX_RDaddr_i == IFID_RS2addr_i)));
    freeze = ICache_stall_i || DCache_stall_i;
  end

  // Next-state and control decode; freeze outranks stall, stall outranks branch.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    br_pend_d    = br_pend_q;
    stall_c      = 1'b0;
    flush_ifid_c = 1'b0;
    flush_idex_c = 1'b0;
    if (freeze) begin
      // Nothing advances; a redirect seen now is remembered for later.
      if ((state_q == HZ_IDLE) && BranchOrJump_i) begin
        br_pend_d = 1'b1;
        state_d   = HZ_BR_PEND;
      end
    end else begin
      case (state_q)
        HZ_IDLE: begin
          if (lu_hit) begin
            // Branch is dropped here: it depends on the load and resolves again later.
            stall_c      = 1'b1;
            flush_idex_c = 1'b1;
            if (MULTI_BUBBLE) begin
              cnt_d   = CNT_W'(LU_STALL_CYC - 1);
              state_d = HZ_LU_STALL;
            end
          end else if (BranchOrJump_i) begin
            flush_ifid_c = 1'b1;
            flush_idex_c = 1'b1;
          end
        end
        HZ_LU_STALL: begin
          stall_c      = 1'b1;
          flush_idex_c = 1'b1;
          cnt_d        = cnt_q - CNT_W'(1);
          if (cnt_q <= CNT_W'(1)) begin
            state_d = HZ_IDLE;
          end
        end
        HZ_BR_PEND: begin
          // Deferred redirect: one flush, then the latch is consumed.
          flush_ifid_c = br_pend_q;
          flush_idex_c = br_pend_q;
          br_pend_d    = 1'b0;
          state_d      = HZ_IDLE;
        end
        default: begin
          state_d   = HZ_IDLE;
          cnt_d     = '0;
          br_pend_d = 1'b0;
        end
      endcase
    end
  end

  // FSM state, bubble counter and deferred-branch latch.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= HZ_IDLE;
      cnt_q     <= '0;
      br_pend_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      br_pend_q <= br_pend_d;
    end
  end

  // Controls are gated by reset so they drop the instant rst_n falls.
  always_comb begin
    Stall_load_use_o = rst_n && stall_c;
    Flush_IFID_o     = rst_n && flush_ifid_c;
    Flush_IDEX_o     = rst_n && flush_idex_c;
    Freeze_o         = rst_n && freeze;
    State_o          = state_q;
  end

`ifdef HAZARD_PERF_CNT_EN
  hazard_perf_cnt u_perf_cnt (
    .clk_i          (clk_i),
    .rst_n          (rst_n),
    .stall_i        (Stall_load_use_o),
    .freeze_i       (Freeze_o),
    .flush_i        (Flush_IFID_o),
    .LU_stall_cnt_o (LU_stall_cnt_o),
    .Freeze_cnt_o   (Freeze_cnt_o),
    .Flush_cnt_o    (Flush_cnt_o)
  );
`endif

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Self-checking bench for hazard_ctrl_unit. Two instances (1 and 3 bubbles)
// share the same stimulus and are compared against a behavioural model that
// tracks remaining bubbles and a pending-branch flag.
module tb_hazard_ctrl_unit;

  logic       clk;
  logic       rst_n;
  logic       mem_read;
  logic [4:0] rd_addr;
  logic [4:0] rs1_addr;
  logic [4:0] rs2_addr;
  logic       rs1_used;
  logic       rs2_used;
  logic       br;
  logic       ic_stall;
  logic       dc_stall;

  logic [1:0] stall_o;
  logic [1:0] fl_ifid_o;
  logic [1:0] fl_idex_o;
  logic [1:0] freeze_o;
  logic [1:0] state_o [2];
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] lu_cnt [2];
  logic [31:0] fz_cnt [2];
  logic [31:0] fl_cnt [2];
  int          m_lu [2];
  int          m_fz [2];
  int          m_fl [2];
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: bubbles still owed after the current one, and a deferred branch.
  int rem  [2];
  bit pend [2];
  int nbub [2];

  // Observed-event tallies used by directed scenarios.
  int stall_seen [2];
  int flush_seen [2];

  hazard_ctrl_unit #(.REG_ADDR_W(5), .LU_STALL_CYC(1), .CNT_W(3)) u_dut1 (
    .clk_i            (clk),
    .rst_n            (rst_n),
    .IDEX_MemRead_i   (mem_read),
    .IDEX_RDaddr_i    (rd_addr),
    .IFID_RS1addr_i   (rs1_addr),
    .IFID_RS2addr_i   (rs2_addr),
    .IFID_RS1used_i   (rs1_used),
    .IFID_RS2used_i   (rs2_used),
    .BranchOrJump_i   (br),
    .ICache_stall_i   (ic_stall),
    .DCache_stall_i   (dc_stall),
    .Stall_load_use_o (stall_o[0]),
    .Flush_IFID_o     (fl_ifid_o[0]),
    .Flush_IDEX_o     (fl_idex_o[0]),
    .Freeze_o         (freeze_o[0]),
    .State_o          (state_o[0])
`ifdef HAZARD_PERF_CNT_EN
    ,
    .LU_stall_cnt_o   (lu_cnt[0]),
    .Freeze_cnt_o     (fz_cnt[0]),
    .Flush_cnt_o      (fl_cnt[0])
`endif
  );

  hazard_ctrl_unit #(.REG_ADDR_W(5), .LU_STALL_CYC(3), .CNT_W(3)) u_dut3 (
    .clk_i            (clk),
    .rst_n            (rst_n),
    .IDEX_MemRead_i   (mem_read),
    .IDEX_RDaddr_i    (rd_addr),
    .IFID_RS1addr_i   (rs1_addr),
    .IFID_RS2addr_i   (rs2_addr),
    .IFID_RS1used_i   (rs1_used),
    .IFID_RS2used_i   (rs2_used),
    .BranchOrJump_i   (br),
    .ICache_stall_i   (ic_stall),
    .DCache_stall_i   (dc_stall),
    .Stall_load_use_o (stall_o[1]),
    .Flush_IFID_o     (fl_ifid_o[1]),
    .Flush_IDEX_o     (fl_idex_o[1]),
    .Freeze_o         (freeze_o[1]),
    .State_o          (state_o[1])
`ifdef HAZARD_PERF_CNT_EN
    ,
    .LU_stall_cnt_o   (lu_cnt[1]),
    .Freeze_cnt_o     (fz_cnt[1]),
    .Flush_cnt_o      (fl_cnt[1])
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Apply one cycle of inputs, check both instances, advance the model.
  task automatic cycle(input bit mr, input logic [4:0] rd, input logic [4:0] r1,
                       input logic [4:0] r2, input bit u1, input bit u2,
                       input bit b, input bit ic, input bit dc, input bit rn);
    bit lu;
    bit fz;
    @(negedge clk);
    mem_read = mr; rd_addr = rd; rs1_addr = r1; rs2_addr = r2;
    rs1_used = u1; rs2_used = u2; br = b; ic_stall = ic; dc_stall = dc; rst_n = rn;
    #1;
    lu = mr && (rd != 0) && ((u1 && rd == r1) || (u2 && rd == r2));
    fz = ic || dc;
    for (int k = 0; k < 2; k++) begin
      bit es, ei, ed, ef;
      logic [1:0] est;
      es = 0; ei = 0; ed = 0; ef = 0;
      est = (rem[k] > 0) ? 2'd1 : (pend[k] ? 2'd2 : 2'd0);
      if (!rn) begin
        est = 2'd0; rem[k] = 0; pend[k] = 0;
      end else if (fz) begin
        ef = 1;
        if (rem[k] == 0 && !pend[k] && b) pend[k] = 1;
      end else if (rem[k] > 0) begin
        es = 1; ed = 1; rem[k]--;
      end else if (pend[k]) begin
        ei = 1; ed = 1; pend[k] = 0;
      end else if (lu) begin
        es = 1; ed = 1; rem[k] = nbub[k] - 1;
      end else if (b) begin
        ei = 1; ed = 1;
      end
      check_eq($sformatf("stall[%0d]", nbub[k]),   stall_o[k],   es);
      check_eq($sformatf("fl_ifid[%0d]", nbub[k]), fl_ifid_o[k], ei);
      check_eq($sformatf("fl_idex[%0d]", nbub[k]), fl_idex_o[k], ed);
      check_eq($sformatf("freeze[%0d]", nbub[k]),  freeze_o[k],  ef);
      check_eq($sformatf("state[%0d]", nbub[k]),   state_o[k],   est);
`ifdef HAZARD_PERF_CNT_EN
      if (!rn) begin m_lu[k] = 0; m_fz[k] = 0; m_fl[k] = 0; end
      check_eq($sformatf("lu_cnt[%0d]", nbub[k]), lu_cnt[k], m_lu[k]);
      check_eq($sformatf("fz_cnt[%0d]", nbub[k]), fz_cnt[k], m_fz[k]);
      check_eq($sformatf("fl_cnt[%0d]", nbub[k]), fl_cnt[k], m_fl[k]);
      if (rn) begin m_lu[k] += es; m_fz[k] += ef; m_fl[k] += ei; end
`endif
      stall_seen[k] += int'(stall_o[k]);
      flush_seen[k] += int'(fl_ifid_o[k]);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
  endtask

  task automatic clear_seen();
    for (int k = 0; k < 2; k++) begin stall_seen[k] = 0; flush_seen[k] = 0; end
  endtask

  initial begin
    nbub[0] = 1; nbub[1] = 3;
    for (int k = 0; k < 2; k++) begin
      rem[k] = 0; pend[k] = 0; stall_seen[k] = 0; flush_seen[k] = 0;
`ifdef HAZARD_PERF_CNT_EN
      m_lu[k] = 0; m_fz[k] = 0; m_fl[k] = 0;
`endif
    end
    rst_n = 0; mem_read = 0; rd_addr = 0; rs1_addr = 0; rs2_addr = 0;
    rs1_used = 0; rs2_used = 0; br = 0; ic_stall = 0; dc_stall = 0;

    // Reset with a live hazard on the inputs: everything must stay quiet.
    cycle(1, 5, 5, 0, 1, 0, 1, 0, 0, 0);
    cycle(1, 5, 5, 0, 1, 0, 1, 0, 0, 0);
    idle(2);

    // Basic load-use on rs1.
    clear_seen();
    cycle(1, 5, 5, 0, 1, 0, 0, 0, 0, 1);
    idle(4);
    check_eq("lu_total_1", stall_seen[0], 1);
    check_eq("lu_total_3", stall_seen[1], 3);

    // Qualifiers: x0 destination, unused rs2, used rs2.
    clear_seen();
    cycle(1, 0, 0, 0, 1, 1, 0, 0, 0, 1);
    cycle(1, 5, 1, 5, 1, 0, 0, 0, 0, 1);
    check_eq("no_stall_x0_unused", stall_seen[1], 0);
    cycle(1, 7, 1, 7, 1, 1, 0, 0, 0, 1);
    idle(4);
    check_eq("rs2_stall_1", stall_seen[0], 1);

    // Multi-cycle stall with a 2-cycle D-cache freeze in the middle.
    clear_seen();
    cycle(1, 6, 6, 0, 1, 0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    idle(4);
    check_eq("lu_frozen_total_3", stall_seen[1], 3);

    // Branch alone, then branch together with a load-use hit.
    clear_seen();
    cycle(0, 0, 0, 0, 0, 0, 1, 0, 0, 1);
    check_eq("br_flush", flush_seen[0], 1);
    cycle(1, 9, 9, 0, 1, 0, 1, 0, 0, 1);
    idle(4);
    check_eq("br_lu_no_ifid_flush", flush_seen[1], 1);

    // Deferred branch held high through a 4-cycle I-cache freeze.
    clear_seen();
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0, 0, 0, 1, 1, 0, 1);
    check_eq("defer_no_flush", flush_seen[0], 0);
    cycle(0, 0, 0, 0, 0, 0, 1, 0, 0, 1);
    idle(2);
    check_eq("defer_one_flush", flush_seen[0], 1);
    check_eq("defer_state_idle", state_o[0], 0);

    // Asynchronous reset mid-stall.
    cycle(1, 4, 4, 0, 1, 0, 0, 0, 0, 1);
    cycle(1, 4, 4, 0, 1, 0, 0, 0, 0, 0);
    check_eq("reset_mid_state", state_o[1], 0);
    idle(2);

    // Randomised traffic with occasional resets.
    for (int i = 0; i < 800; i++) begin
      cycle($urandom_range(0, 1), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)), $urandom_range(0, 1), $urandom_range(0, 1),
            ($urandom_range(0, 9) < 3), ($urandom_range(0, 9) == 0),
            ($urandom_range(0, 9) == 0), ($urandom_range(0, 99) != 0));
    end
    idle(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
